data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single 18-bit-wide, 16-bit-addressed data memory port between the asm18 CPU load/store unit and the UART debug controller.
- Round-robin arbitration between the two masters, with a debug lock that gives the UART side exclusive access for bursts.
- Issues one access per cycle through a registered memory-side stage.
- Routes synchronous read data back to the requester that issued the read, using an in-flight tag pipeline.

Parameters:
- READ_LATENCY, 1, cycles from the registered mem_address to a valid mem_read (1..4).

Ports:
- clk_50M  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  18  CPU write data
- cpu_gnt  out  1  combinational: CPU access accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  18  CPU read data
- cpu_stall  out  1  cpu_req && !cpu_gnt
- dbg_req, dbg_we, dbg_addr[16], dbg_wdata[18], dbg_gnt, dbg_rvalid, dbg_rdata[18]: same semantics, UART debug side
- dbg_lock  in  1  while high, the CPU is never granted
- mem_address  out  16  registered memory address
- mem_write  out  18  registered write data
- mem_wren  out  1  registered write enable, one-cycle pulse per write
- mem_read  in  18  memory read data

Behaviour:
- Reset (async, rst_n low) sets:
  - mem_address=0, mem_write=0, mem_wren=0
  - last_winner=DBG, so the CPU wins the first tie
  - all in-flight read tags cleared
  - cpu_rvalid=dbg_rvalid=0
- rdata outputs are a combinational pass-through of mem_read.
- Grant (combinational, cycle N):
  - dbg_lock=1: dbg_gnt=dbg_req, cpu_gnt=0.
  - Otherwise, single requester: that requester is granted.
  - Otherwise, both requesting: grant goes to the master that is not last_winner.
  - last_winner updates on every grant.
  - At most one gnt per cycle.
- Requester rules:
  - addr/we/wdata must be stable while req is high and not granted.
  - A new request may be presented in the cycle after gnt; back-to-back grants to the same master are allowed.
- Issue (cycle N+1): the winner's addr/wdata are registered onto mem_address/mem_write, and mem_wren=we.
- No grant in cycle N:
  - mem_wren=0 in N+1.
  - mem_address and mem_write hold their previous values.
- Read return:
  - A granted read pushes tag {valid=1, owner} into a READ_LATENCY+1 deep shift register.
  - At the end of the shift register, the owner's rvalid is a 1-cycle pulse in cycle N+1+READ_LATENCY.
  - The owner's rdata equals mem_read in that cycle.
  - The other master's rvalid stays 0.
  - Writes push an invalid tag.
- Throughput: one access per cycle, fully pipelined. Reads and writes may interleave freely. Reads return in issue order.
- Read-after-write ordering:
  - A write and a subsequent read to the same address, from either master, is ordered by issue.
  - The read returns the new data, relying on the memory's write-before-read behaviour at a later cycle.
- dbg_lock:
  - Asserting it mid-stream does not cancel CPU reads already in flight; their rvalid still arrives.
  - Deasserting it resumes round-robin from the current last_winner.
- Simultaneous events: grant and rvalid for the same master in the same cycle are independent and both occur.
- Reset mid-operation: pending tags are discarded, so no rvalid occurs after reset release for reads issued before reset.
- Idle: no requests means mem_wren=0 and no tags.

Test Plan:
- Reset, then cpu_req read addr=0x0010 with memory[0x10]=0x2A5A5 → cpu_gnt in the same cycle; mem_address=0x0010 next cycle; cpu_rvalid=1 with cpu_rdata=0x2A5A5 exactly 2 cycles after gnt (READ_LATENCY=1); dbg_rvalid stays 0.
- cpu_req and dbg_req both held high with continuous reads for 6 cycles → grants alternate CPU,DBG,CPU,DBG,CPU,DBG; each rvalid is routed to the correct master, in order; cpu_stall=1 on every DBG cycle.
- dbg_lock=1 with both requesting for 5 cycles → dbg_gnt on all 5 and cpu_gnt=0, cpu_stall=1; drop the lock → the CPU is granted on the next tie.
- dbg write addr=0x0100 data=0x3FFFF, then cpu read of 0x0100 the next cycle → mem_wren pulses once; cpu_rdata=0x3FFFF.
- CPU read granted, rst_n pulsed low 1 cycle later → all outputs return to reset values asynchronously; no cpu_rvalid ever appears for that read.
- READ_LATENCY=3, four back-to-back reads alternating masters → each rvalid arrives 4 cycles after its gnt, in issue order, to the correct owner.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Arbitrates the shared data memory port between the CPU load/store unit and
// the UART debug controller. Round-robin between the two masters with a debug
// lock; one registered access per cycle; read data is returned to its issuer
// through an in-flight tag shift register.
module data_mem_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  // CPU load/store side
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [17:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [17:0] cpu_rdata,
  output logic        cpu_stall,
  // UART debug side
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [17:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [17:0] dbg_rdata,
  input  logic        dbg_lock,
  // Memory side
  output logic [15:0] mem_address,
  output logic [17:0] mem_write,
  output logic        mem_wren,
  input  logic [17:0] mem_read
);

  // One tag slot per cycle between grant and data return.
  localparam int unsigned Depth = READ_LATENCY + 1;

  typedef enum logic {OwnCpu = 1'b0, OwnDbg = 1'b1} owner_e;

  owner_e           last_winner_q, last_winner_d;
  logic [Depth-1:0] tag_valid_q;
  logic [Depth-1:0] tag_owner_q;
  logic             any_gnt;
  logic             sel_dbg;
  logic             push_read;

  // Grant decision: lock forces debug-only, otherwise round-robin on ties.
  always_comb begin
    cpu_gnt       = 1'b0;
    dbg_gnt       = 1'b0;
    last_winner_d = last_winner_q;
    if (dbg_lock) begin
      dbg_gnt = dbg_req;
    end else if (cpu_req && dbg_req) begin
      cpu_gnt = (last_winner_q == OwnDbg);
      dbg_gnt = (last_winner_q == OwnCpu);
    end else begin
      cpu_gnt = cpu_req;
      dbg_gnt = dbg_req;
    end
    if (cpu_gnt) begin
      last_winner_d = OwnCpu;
    end else if (dbg_gnt) begin
      last_winner_d = OwnDbg;
    end
  end

  assign any_gnt   = cpu_gnt | dbg_gnt;
  assign sel_dbg   = dbg_gnt;
  assign push_read = any_gnt && !(sel_dbg ? dbg_we : cpu_we);
  assign cpu_stall = cpu_req && !cpu_gnt;

  // Round-robin history; reset favours the CPU on the first tie.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_q <= OwnDbg;
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

  // Memory-side issue stage: address/data hold when idle, wren is a pulse.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      mem_address <= '0;
      mem_write   <= '0;
      mem_wren    <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      if (any_gnt) begin
        mem_address <= sel_dbg ? dbg_addr  : cpu_addr;
        mem_write   <= sel_dbg ? dbg_wdata : cpu_wdata;
        mem_wren    <= sel_dbg ? dbg_we    : cpu_we;
      end
    end
  end

  // In-flight read tags; the last slot lines up with valid mem_read data.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q <= '0;
      tag_owner_q <= '0;
    end else begin
      tag_valid_q <= {tag_valid_q[Depth-2:0], push_read};
      tag_owner_q <= {tag_owner_q[Depth-2:0], sel_dbg};
    end
  end

  assign cpu_rvalid = tag_valid_q[Depth-1] && (tag_owner_q[Depth-1] == OwnCpu);
  assign dbg_rvalid = tag_valid_q[Depth-1] && (tag_owner_q[Depth-1] == OwnDbg);
  assign cpu_rdata  = mem_read;
  assign dbg_rdata  = mem_read;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter. Two instances share all requester
// inputs: one with READ_LATENCY=1, one with READ_LATENCY=3, each backed by
// its own synchronous memory model.
module tb_data_mem_arbiter;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [15:0] cpu_addr, dbg_addr;
  logic [17:0] cpu_wdata, dbg_wdata;
  logic        preload;

  // Latency-1 instance
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, mem_wren;
  logic [17:0] cpu_rdata, dbg_rdata, mem_write, mem_read;
  logic [15:0] mem_address;
  // Latency-3 instance
  logic        b_cpu_gnt, b_cpu_rvalid, b_cpu_stall, b_dbg_gnt, b_dbg_rvalid, b_mem_wren;
  logic [17:0] b_cpu_rdata, b_dbg_rdata, b_mem_write, b_mem_read;
  logic [15:0] b_mem_address;

  logic [17:0] mem_a [0:511];
  logic [17:0] mem_b [0:511];
  logic [17:0] pipe_b [0:2];

  int total = 0;
  int bad   = 0;
  int cpu_n, dbg_n;
  logic exp_c, exp_d;

  always #5 clk_50M = ~clk_50M;

  data_mem_arbiter #(.READ_LATENCY(1)) dut_a (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_lock(dbg_lock),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wren(mem_wren),
    .mem_read(mem_read)
  );

  data_mem_arbiter #(.READ_LATENCY(3)) dut_b (
    .clk_50M(clk_50M), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .cpu_stall(b_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid), .dbg_rdata(b_dbg_rdata),
    .dbg_lock(dbg_lock),
    .mem_address(b_mem_address), .mem_write(b_mem_write), .mem_wren(b_mem_wren),
    .mem_read(b_mem_read)
  );

  function automatic logic [17:0] init_val(input int k);
    case (k)
      'h10:    return 18'h2A5A5;
      'h20:    return 18'h01111;
      'h40:    return 18'h00100;
      'h41:    return 18'h00101;
      'h42:    return 18'h00102;
      'h50:    return 18'h00200;
      'h51:    return 18'h00201;
      'h52:    return 18'h00202;
      'h60:    return 18'h3C3C3;
      'h61:    return 18'h12345;
      default: return 18'h00000;
    endcase
  endfunction

  // Latency-1 memory: write-before-read, one registered read stage.
  always @(posedge clk_50M) begin
    if (preload) begin
      for (int k = 0; k < 512; k++) mem_a[k] <= init_val(k);
    end else begin
      if (mem_wren) mem_a[mem_address[8:0]] <= mem_write;
      mem_read <= mem_wren ? mem_write : mem_a[mem_address[8:0]];
    end
  end

  // Latency-3 memory: same array behaviour, three read stages.
  always @(posedge clk_50M) begin
    if (preload) begin
      for (int k = 0; k < 512; k++) mem_b[k] <= init_val(k);
    end else begin
      if (b_mem_wren) mem_b[b_mem_address[8:0]] <= b_mem_write;
      pipe_b[0] <= b_mem_wren ? b_mem_write : mem_b[b_mem_address[8:0]];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end
  assign b_mem_read = pipe_b[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next();
    @(posedge clk_50M);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1; dbg_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    next();
    preload = 1'b0;
    next();
    #1;
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_wren", 32'(mem_wren), 32'h0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    rst_n = 1'b1;

    // Single CPU read of 0x0010
    next(); cpu_req = 1'b1; cpu_addr = 16'h0010; #1;
    chk("t1_cpu_gnt", 32'(cpu_gnt), 32'h1);
    chk("t1_dbg_gnt", 32'(dbg_gnt), 32'h0);
    chk("t1_cpu_stall", 32'(cpu_stall), 32'h0);
    next(); cpu_req = 1'b0; #1;
    chk("t1_mem_address", 32'(mem_address), 32'h0010);
    chk("t1_mem_wren", 32'(mem_wren), 32'h0);
    chk("t1_early_rvalid", 32'(cpu_rvalid), 32'h0);
    next(); #1;
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'h2A5A5);
    chk("t1_dbg_rvalid", 32'(dbg_rvalid), 32'h0);
    next(); #1;
    chk("t1_rvalid_pulse", 32'(cpu_rvalid), 32'h0);
    chk("idle_wren", 32'(mem_wren), 32'h0);

    // Single debug read of 0x0020; makes DBG the last winner
    next(); dbg_req = 1'b1; dbg_addr = 16'h0020; #1;
    chk("d_dbg_gnt", 32'(dbg_gnt), 32'h1);
    next(); dbg_req = 1'b0;
    next(); #1;
    chk("d_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    chk("d_dbg_rdata", 32'(dbg_rdata), 32'h01111);
    chk("d_cpu_rvalid", 32'(cpu_rvalid), 32'h0);

    // Both masters streaming reads: CPU,DBG,CPU,DBG,CPU,DBG
    cpu_n = 0; dbg_n = 0;
    for (int i = 0; i < 8; i++) begin
      next();
      cpu_req = (cpu_n < 3); dbg_req = (dbg_n < 3);
      cpu_addr = 16'(32'h40 + cpu_n); dbg_addr = 16'(32'h50 + dbg_n);
      #1;
      if (i < 6) begin
        chk("rr_cpu_gnt", 32'(cpu_gnt), 32'(i % 2 == 0));
        chk("rr_dbg_gnt", 32'(dbg_gnt), 32'(i % 2 == 1));
        chk("rr_cpu_stall", 32'(cpu_stall), 32'(i % 2 == 1 && i < 5));
        if (i % 2 == 0) cpu_n++; else dbg_n++;
      end
      if (i >= 2) begin
        exp_c = ((i - 2) % 2 == 0);
        chk("rr_cpu_rvalid", 32'(cpu_rvalid), 32'(exp_c));
        chk("rr_dbg_rvalid", 32'(dbg_rvalid), 32'(!exp_c));
        if (exp_c) chk("rr_cpu_rdata", 32'(cpu_rdata), 32'(32'h100 + (i - 2) / 2));
        else       chk("rr_dbg_rdata", 32'(dbg_rdata), 32'(32'h200 + (i - 2) / 2));
      end
    end

    // CPU read in flight when the lock rises; lock holds DBG for 5 cycles
    next(); cpu_req = 1'b1; cpu_addr = 16'h0060; dbg_req = 1'b1; dbg_addr = 16'h0050; #1;
    chk("lk_pre_cpu_gnt", 32'(cpu_gnt), 32'h1);
    chk("lk_pre_dbg_gnt", 32'(dbg_gnt), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      next(); dbg_lock = 1'b1; cpu_addr = 16'h0061; #1;
      chk("lk_dbg_gnt", 32'(dbg_gnt), 32'h1);
      chk("lk_cpu_gnt", 32'(cpu_gnt), 32'h0);
      chk("lk_cpu_stall", 32'(cpu_stall), 32'h1);
      chk("lk_cpu_rvalid", 32'(cpu_rvalid), 32'(i == 2));
      if (i == 2) chk("lk_cpu_rdata", 32'(cpu_rdata), 32'h3C3C3);
      chk("lk_dbg_rvalid", 32'(dbg_rvalid), 32'(i >= 3));
      if (i >= 3) chk("lk_dbg_rdata", 32'(dbg_rdata), 32'h00200);
    end
    next(); dbg_lock = 1'b0; #1;
    chk("unlk_cpu_gnt", 32'(cpu_gnt), 32'h1);
    chk("unlk_dbg_gnt", 32'(dbg_gnt), 32'h0);
    chk("unlk_dbg_rvalid", 32'(dbg_rvalid), 32'h1);
    next(); cpu_req = 1'b0; dbg_req = 1'b0; #1;
    chk("unlk_dbg_rvalid2", 32'(dbg_rvalid), 32'h1);
    chk("unlk_cpu_rvalid0", 32'(cpu_rvalid), 32'h0);
    next(); #1;
    chk("unlk_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("unlk_cpu_rdata", 32'(cpu_rdata), 32'h12345);

    // Debug write to 0x0100 followed by CPU read of 0x0100
    next(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0100; dbg_wdata = 18'h3FFFF; #1;
    chk("raw_dbg_gnt", 32'(dbg_gnt), 32'h1);
    next(); dbg_req = 1'b0; dbg_we = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0100; #1;
    chk("raw_cpu_gnt", 32'(cpu_gnt), 32'h1);
    chk("raw_wren", 32'(mem_wren), 32'h1);
    chk("raw_waddr", 32'(mem_address), 32'h0100);
    chk("raw_wdata", 32'(mem_write), 32'h3FFFF);
    chk("raw_no_rvalid", 32'(dbg_rvalid), 32'h0);
    next(); cpu_req = 1'b0; #1;
    chk("raw_wren_pulse", 32'(mem_wren), 32'h0);
    chk("raw_raddr", 32'(mem_address), 32'h0100);
    next(); #1;
    chk("raw_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("raw_cpu_rdata", 32'(cpu_rdata), 32'h3FFFF);

    // Reset one cycle after a granted CPU read
    next(); cpu_req = 1'b1; cpu_addr = 16'h0010; #1;
    chk("mr_cpu_gnt", 32'(cpu_gnt), 32'h1);
    next(); cpu_req = 1'b0; #1;
    chk("mr_pre_addr", 32'(mem_address), 32'h0010);
    rst_n = 1'b0; #1;
    chk("mr_async_addr", 32'(mem_address), 32'h0);
    chk("mr_async_wdata", 32'(mem_write), 32'h0);
    chk("mr_async_wren", 32'(mem_wren), 32'h0);
    chk("mr_async_b_addr", 32'(b_mem_address), 32'h0);
    next(); rst_n = 1'b1; #1;
    chk("mr_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      next(); #1;
      chk("mr_cpu_rvalid_post", 32'(cpu_rvalid), 32'h0);
      chk("mr_b_cpu_rvalid_post", 32'(b_cpu_rvalid), 32'h0);
    end

    // Latency-3 instance: four back-to-back reads alternating masters
    for (int i = 0; i < 9; i++) begin
      next();
      cpu_req = (i == 0 || i == 2); dbg_req = (i == 1 || i == 3);
      cpu_we = 1'b0; dbg_we = 1'b0;
      cpu_addr = 16'(32'h40 + i / 2); dbg_addr = 16'(32'h50 + i / 2);
      #1;
      if (i < 4) begin
        chk("l3_cpu_gnt", 32'(b_cpu_gnt), 32'(i % 2 == 0));
        chk("l3_dbg_gnt", 32'(b_dbg_gnt), 32'(i % 2 == 1));
        chk("l3_cpu_stall", 32'(b_cpu_stall), 32'h0);
      end
      exp_c = (i == 4 || i == 6);
      exp_d = (i == 5 || i == 7);
      chk("l3_cpu_rvalid", 32'(b_cpu_rvalid), 32'(exp_c));
      chk("l3_dbg_rvalid", 32'(b_dbg_rvalid), 32'(exp_d));
      if (exp_c) chk("l3_cpu_rdata", 32'(b_cpu_rdata), 32'(32'h100 + (i - 4) / 2));
      if (exp_d) chk("l3_dbg_rdata", 32'(b_dbg_rdata), 32'(32'h200 + (i - 5) / 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
